mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit that sequences the shared datapath: PC, single-port synchronous instruction/data memory, instruction register, register file and ALU.
- Replaces per-instruction combinational control with a Moore FSM.
- Inserts wait cycles for synchronous-memory read latency.
- Emits all datapath selects and enables, plus a done pulse and a sticky illegal flag.
- Sits beside the datapath in top, clocked by the divided clock.

Parameters:
MEM_WAIT, 1, extra wait cycles before memory read data is valid (0..7); applies in FETCH and MEMRD.

Ports:
clk  in  1  datapath clock (divided clock)
clr_n  in  1  asynchronous active-low reset
op  in  6  instruction[31:26], from the instruction register
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag
pc_en  out  1  PC load enable = pcwrite | (branch & zero)
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write enable
irwrite  out  1  instruction register load
regdst  out  1  register write address: 0=rt, 1=rd
memtoreg  out  1  register write data: 0=ALUOut, 1=MDR
regwrite  out  1  register file write enable
alusrca  out  1  ALU A input: 0=PC, 1=regA
alusrcb  out  2  ALU B input: 00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal  out  1  high while in ILLEGAL
state  out  4  current state code, for debug

Behaviour:
- Reset and clocking:
  - clr_n low: state=FETCH, wait_cnt=0.
  - While clr_n is low, every output except state is forced to 0 combinationally.
  - Reset is honoured at any point, including mid-instruction or mid-wait.
  - All transitions occur on the clk rising edge.
- Outputs are a Moore function of state plus wait_cnt. Exception: pc_en also depends on zero.
- Any output not listed for a state is 0. alucontrol defaults to 010 (add).
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ILLEGAL 15. Unused codes 12-14 go to ILLEGAL.
- FETCH:
  - Outputs every cycle: iord=0, alusrca=0, alusrcb=01, add.
  - While wait_cnt<MEM_WAIT: wait_cnt increments; irwrite=pcwrite=0.
  - When wait_cnt==MEM_WAIT: irwrite=1, pcwrite=1, pcsrc=00; wait_cnt clears to 0; next state DECODE.
- DECODE: alusrca=0, alusrcb=11, add. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> REX if funct is one of 100000/100010/100100/100101/101010, else ILLEGAL.
  - 000100 (beq) -> BEQEX.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JEX.
  - Any other op -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1, held stable through the wait. Uses the same wait_cnt rule as FETCH; at wait_cnt==MEM_WAIT -> MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 for exactly one cycle, instr_done=1 -> FETCH.
- REX: alusrca=1, alusrcb=00, alucontrol from funct -> RWB.
- RWB: regdst=1, regwrite=1, instr_done=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01, instr_done=1 -> FETCH.
  - pc_en = zero in this state.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regwrite=1, instr_done=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1, instr_done=1 -> FETCH.
- ILLEGAL: illegal=1, all enables 0. Remains until reset.
- Invariant: memwrite, regwrite and irwrite are never asserted in the same cycle.
- Cycle counts at MEM_WAIT=W:
  - lw = 5+2W
  - sw = 4+W
  - R-type = 4+W
  - addi = 4+W
  - beq = 3+W
  - j = 3+W

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode and funct constants;
  - 4-bit state codes;
  - alusrcb, pcsrc and alucontrol encodings;
  - aluop codes: 00 add, 01 sub, 10 funct.
- Sub-module alu_decoder: combinational; aluop[1:0] + funct[5:0] -> alucontrol[2:0] plus funct_valid. funct_valid also drives the DECODE illegal check.

Test Plan:
- Reset: hold clr_n=0 for 3 cycles, then release with op=100011, MEM_WAIT=1 -> all outputs 0 during reset; state=0; first cycle after release: iord=0, alusrcb=01, irwrite=0; next cycle: irwrite=1, pc_en=1.
- lw at MEM_WAIT=1 -> state sequence 0,0,1,2,3,3,4; iord=1 in both MEMRD cycles; regwrite=1 and memtoreg=1 only in state 4; instr_done asserted on cycle 7 only.
- beq, run twice -> zero=1 gives pc_en=1, pcsrc=01, alucontrol=110 in BEQEX; zero=0 gives pc_en=0; both take 4 cycles.
- R-type funct=101010 -> alucontrol=111 in REX, regdst=1 in RWB; repeat with funct=000111 -> state 15, illegal=1, held 10 cycles with all enables 0; clr_n pulse returns to FETCH.
- j then sw -> JEX: pcsrc=10, pc_en=1; sw: memwrite=1 for exactly one cycle; instr_done once per instruction.
- Reset asserted in the second MEMRD cycle -> outputs go 0 immediately without waiting for clk; after release, state=0 and wait_cnt=0 (FETCH takes 2 cycles again); no regwrite occurs.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct
// codes, FSM state codes and the datapath select/ALU control encodings.
package mc_ctrl_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // FSM state codes; these values are visible on the debug state port
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REX     = 4'd6,
        S_RWB     = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    // ALU B input select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class requested by the FSM
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // True for the two opcodes that go through the address-calculation state
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus the
// R-type funct field to the 3-bit ALU control, and flags supported functs.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_valid
);

    logic [2:0] funct_ctrl_s;

    // Translate the funct field and note whether it is a supported R-type op
    always_comb begin
        funct_ctrl_s = ALU_ADD;
        funct_valid  = 1'b0;
        case (funct)
            FN_ADD: begin funct_ctrl_s = ALU_ADD; funct_valid = 1'b1; end
            FN_SUB: begin funct_ctrl_s = ALU_SUB; funct_valid = 1'b1; end
            FN_AND: begin funct_ctrl_s = ALU_AND; funct_valid = 1'b1; end
            FN_OR:  begin funct_ctrl_s = ALU_OR;  funct_valid = 1'b1; end
            FN_SLT: begin funct_ctrl_s = ALU_SLT; funct_valid = 1'b1; end
            default: begin funct_ctrl_s = ALU_ADD; funct_valid = 1'b0; end
        endcase
    end

    // Select between fixed add/sub and the funct-derived operation
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_ctrl_s;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit. A Moore FSM sequences the shared datapath
// (PC, single-port synchronous memory, IR, register file, ALU), inserting
// MEM_WAIT extra cycles wherever memory read data is consumed.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    import mc_ctrl_pkg::*;

    localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

    state_t     state_r;
    logic [2:0] wait_cnt_r;
    logic       wait_done_s;

    logic       pcwrite_s;
    logic       branch_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop_s;
    logic       done_s;
    logic       illegal_s;
    logic [2:0] alu_ctrl_s;
    logic       funct_valid_s;

    assign wait_done_s = (wait_cnt_r == WAIT_MAX);

    alu_decoder u_alu_decoder (
        .aluop       (aluop_s),
        .funct       (funct),
        .alucontrol  (alu_ctrl_s),
        .funct_valid (funct_valid_s)
    );

    // State register and memory wait counter; the counter is always zero on
    // entry to FETCH/MEMRD because every exit from those states clears it
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 3'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (wait_done_s) begin
                        wait_cnt_r <= 3'd0;
                        state_r    <= S_DECODE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                S_DECODE: begin
                    wait_cnt_r <= 3'd0;
                    case (op)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE:     state_r <= funct_valid_s ? S_REX : S_ILLEGAL;
                        OP_BEQ:       state_r <= S_BEQEX;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        OP_J:         state_r <= S_JEX;
                        default:      state_r <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    wait_cnt_r <= 3'd0;
                    if (op == OP_LW) begin
                        state_r <= S_MEMRD;
                    end else if (op == OP_SW) begin
                        state_r <= S_MEMWR;
                    end else begin
                        state_r <= S_ILLEGAL;
                    end
                end
                S_MEMRD: begin
                    if (wait_done_s) begin
                        wait_cnt_r <= 3'd0;
                        state_r    <= S_MEMWB;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                S_REX: begin
                    wait_cnt_r <= 3'd0;
                    state_r    <= S_RWB;
                end
                S_ADDIEX: begin
                    wait_cnt_r <= 3'd0;
                    state_r    <= S_ADDIWB;
                end
                S_MEMWB, S_MEMWR, S_RWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                    wait_cnt_r <= 3'd0;
                    state_r    <= S_FETCH;
                end
                S_ILLEGAL: begin
                    wait_cnt_r <= 3'd0;
                    state_r    <= S_ILLEGAL;
                end
                default: begin
                    wait_cnt_r <= 3'd0;
                    state_r    <= S_ILLEGAL;
                end
            endcase
        end
    end

    // Moore output decode from the current state and wait counter
    always_comb begin
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = SRCB_REGB;
        pcsrc_s    = PCSRC_ALU;
        aluop_s    = ALUOP_ADD;
        done_s     = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb_s = SRCB_FOUR;
                if (wait_done_s) begin
                    irwrite_s = 1'b1;
                    pcwrite_s = 1'b1;
                    pcsrc_s   = PCSRC_ALU;
                end else begin
                    irwrite_s = 1'b0;
                    pcwrite_s = 1'b0;
                end
            end
            S_DECODE: begin
                alusrcb_s = SRCB_IMM_SL2;
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
            end
            S_MEMRD: begin
                iord_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_REX: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_REGB;
                aluop_s   = ALUOP_FUNCT;
            end
            S_RWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_BEQEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_REGB;
                aluop_s   = ALUOP_SUB;
                branch_s  = 1'b1;
                pcsrc_s   = PCSRC_ALUOUT;
                done_s    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            S_JEX: begin
                pcsrc_s   = PCSRC_JUMP;
                pcwrite_s = 1'b1;
                done_s    = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Reset forces every control output low without waiting for a clock edge
    assign pc_en      = clr_n & (pcwrite_s | (branch_s & zero));
    assign iord       = clr_n & iord_s;
    assign memwrite   = clr_n & memwrite_s;
    assign irwrite    = clr_n & irwrite_s;
    assign regdst     = clr_n & regdst_s;
    assign memtoreg   = clr_n & memtoreg_s;
    assign regwrite   = clr_n & regwrite_s;
    assign alusrca    = clr_n & alusrca_s;
    assign alusrcb    = {2{clr_n}} & alusrcb_s;
    assign pcsrc      = {2{clr_n}} & pcsrc_s;
    assign alucontrol = {3{clr_n}} & alu_ctrl_s;
    assign instr_done = clr_n & done_s;
    assign illegal    = clr_n & illegal_s;
    assign state      = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: an instruction-level model expands
// each instruction into its expected per-cycle control pattern, and a
// compare process checks the DUT against it on every cycle out of reset.
module tb_mc_ctrl_fsm;

    localparam int W = 1;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b1;
    logic [5:0] op    = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero  = 1'b0;
    logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;
    logic [3:0] state;
    logic [16:0] outs;

    mc_ctrl_fsm #(.MEM_WAIT(W)) dut (
        .clk(clk), .clr_n(clr_n), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    assign outs = {pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic pcwrite, branch, done, ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int n_tests = 0, n_fail = 0;
    int cyc_cnt = 0, last_len = 0, done_cnt = 0, mw_cnt = 0;
    int zero_mode = 0;
    int beq_pc_en = 0, beq_pcsrc = 0, beq_aluc = 0;
    int rex_aluc = 0, rwb_regdst = 0, jex_pcsrc = 0, jex_pc_en = 0;

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t blank(input logic [3:0] s);
        exp_t e;
        e.st = s; e.iord = 1'b0; e.memwrite = 1'b0; e.irwrite = 1'b0;
        e.regdst = 1'b0; e.memtoreg = 1'b0; e.regwrite = 1'b0; e.alusrca = 1'b0;
        e.alusrcb = 2'b00; e.pcsrc = 2'b00; e.aluc = 3'b010;
        e.pcwrite = 1'b0; e.branch = 1'b0; e.done = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    // ALU control for a supported R-type funct, -1 when unsupported
    function automatic int funct_ctrl(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // Instruction length in cycles from the published cycle-count table
    function automatic int len_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b100011) return 5 + 2 * W;
        if (o == 6'b101011) return 4 + W;
        if (o == 6'b000000 && funct_ctrl(f) >= 0) return 4 + W;
        if (o == 6'b001000) return 4 + W;
        if (o == 6'b000100) return 3 + W;
        if (o == 6'b000010) return 3 + W;
        return 0;
    endfunction

    // Expand one instruction into its expected cycle-by-cycle behaviour
    task automatic gen(input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        for (int i = 0; i <= W; i++) begin
            e = blank(4'd0); e.alusrcb = 2'b01;
            if (i == W) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
            exp_q.push_back(e);
        end
        e = blank(4'd1); e.alusrcb = 2'b11; exp_q.push_back(e);
        if (o == 6'b100011 || o == 6'b101011) begin
            e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10; exp_q.push_back(e);
            if (o == 6'b100011) begin
                for (int i = 0; i <= W; i++) begin
                    e = blank(4'd3); e.iord = 1'b1; exp_q.push_back(e);
                end
                e = blank(4'd4); e.memtoreg = 1'b1; e.regwrite = 1'b1; e.done = 1'b1;
                exp_q.push_back(e);
            end else begin
                e = blank(4'd5); e.iord = 1'b1; e.memwrite = 1'b1; e.done = 1'b1;
                exp_q.push_back(e);
            end
        end else if (o == 6'b000000 && funct_ctrl(f) >= 0) begin
            e = blank(4'd6); e.alusrca = 1'b1; e.aluc = 3'(funct_ctrl(f)); exp_q.push_back(e);
            e = blank(4'd7); e.regdst = 1'b1; e.regwrite = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
        end else if (o == 6'b000100) begin
            e = blank(4'd8); e.alusrca = 1'b1; e.aluc = 3'b110; e.branch = 1'b1;
            e.pcsrc = 2'b01; e.done = 1'b1; exp_q.push_back(e);
        end else if (o == 6'b001000) begin
            e = blank(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10; exp_q.push_back(e);
            e = blank(4'd10); e.regwrite = 1'b1; e.done = 1'b1; exp_q.push_back(e);
        end else if (o == 6'b000010) begin
            e = blank(4'd11); e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 10; i++) begin
                e = blank(4'd15); e.ill = 1'b1; exp_q.push_back(e);
            end
        end
    endtask

    // Called at posedge+1 of the first FETCH cycle; returns at posedge+1 of the next
    task automatic run(input logic [5:0] o, input logic [5:0] f);
        int d0, cnt;
        op = o; funct = f; d0 = done_cnt;
        gen(o, f);
        cnt = 0;
        do begin @(posedge clk); cnt++; end while (exp_q.size() != 0 && cnt < 100);
        check("queue_drain", exp_q.size(), 0);
        exp_q.delete();
        #1;
        if (len_of(o, f) != 0) begin
            check("done_once", done_cnt - d0, 1);
            check("instr_len", last_len, len_of(o, f));
        end else begin
            check("no_done_illegal", done_cnt - d0, 0);
        end
    endtask

    task automatic do_reset(input int ncyc);
        clr_n = 1'b0;
        #1;
        check("rst_outs_async", int'(outs), 0);
        check("rst_state_async", int'(state), 0);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check("rst_outs", int'(outs), 0);
            check("rst_state", int'(state), 0);
        end
        @(posedge clk); #1;
        clr_n = 1'b1;
    endtask

    // Zero flag driver
    initial forever begin
        @(posedge clk); #1;
        if (zero_mode == 1) zero = 1'b1;
        else if (zero_mode == 2) zero = 1'b0;
        else zero = 1'($urandom_range(0, 1));
    end

    // Compare process: checks every out-of-reset cycle against the model
    initial forever begin
        @(negedge clk);
        if (!clr_n) begin
            cyc_cnt = 0;
        end else begin
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("state", int'(state), int'(cur.st));
                check("pc_en", int'(pc_en), int'(cur.pcwrite | (cur.branch & zero)));
                check("iord", int'(iord), int'(cur.iord));
                check("memwrite", int'(memwrite), int'(cur.memwrite));
                check("irwrite", int'(irwrite), int'(cur.irwrite));
                check("regdst", int'(regdst), int'(cur.regdst));
                check("memtoreg", int'(memtoreg), int'(cur.memtoreg));
                check("regwrite", int'(regwrite), int'(cur.regwrite));
                check("alusrca", int'(alusrca), int'(cur.alusrca));
                check("alusrcb", int'(alusrcb), int'(cur.alusrcb));
                check("pcsrc", int'(pcsrc), int'(cur.pcsrc));
                check("alucontrol", int'(alucontrol), int'(cur.aluc));
                check("instr_done", int'(instr_done), int'(cur.done));
                check("illegal", int'(illegal), int'(cur.ill));
            end
            check("write_exclusive", int'((int'(memwrite) + int'(regwrite) + int'(irwrite)) <= 1), 1);
            cyc_cnt++;
            mw_cnt += int'(memwrite);
            if (instr_done) begin
                last_len = cyc_cnt;
                cyc_cnt  = 0;
                done_cnt++;
            end
            if (state == 4'd8) begin
                beq_pc_en = int'(pc_en); beq_pcsrc = int'(pcsrc); beq_aluc = int'(alucontrol);
            end
            if (state == 4'd6) rex_aluc = int'(alucontrol);
            if (state == 4'd7) rwb_regdst = int'(regdst);
            if (state == 4'd11) begin jex_pcsrc = int'(pcsrc); jex_pc_en = int'(pc_en); end
        end
    end

    initial begin
        int mw0, d0, cnt, k;
        logic [5:0] rfn[5];
        rfn[0] = 6'b100000; rfn[1] = 6'b100010; rfn[2] = 6'b100100;
        rfn[3] = 6'b100101; rfn[4] = 6'b101010;

        op = 6'b100011;
        #2;
        do_reset(3);

        // lw at MEM_WAIT=1: 7 cycles
        run(6'b100011, 6'd0);
        check("lw_len_literal", last_len, 7);

        // beq taken / not taken
        zero_mode = 1;
        run(6'b000100, 6'd0);
        check("beq_taken_pc_en", beq_pc_en, 1);
        check("beq_pcsrc", beq_pcsrc, 1);
        check("beq_aluc", beq_aluc, 6);
        check("beq_len_literal", last_len, 4);
        zero_mode = 2;
        run(6'b000100, 6'd0);
        check("beq_not_taken_pc_en", beq_pc_en, 0);
        check("beq_len_literal2", last_len, 4);
        zero_mode = 0;

        // R-type slt, then an unsupported funct
        run(6'b000000, 6'b101010);
        check("rex_slt_aluc", rex_aluc, 7);
        check("rwb_regdst", rwb_regdst, 1);
        run(6'b000000, 6'b000111);
        check("illegal_state_held", int'(state), 15);
        check("illegal_flag_held", int'(illegal), 1);
        do_reset(1);

        // j then sw
        run(6'b000010, 6'd0);
        check("jex_pcsrc", jex_pcsrc, 2);
        check("jex_pc_en", jex_pc_en, 1);
        mw0 = mw_cnt;
        run(6'b101011, 6'd0);
        check("sw_memwrite_cycles", mw_cnt - mw0, 1);

        // reset in the second MEMRD cycle
        op = 6'b100011; funct = 6'd0; d0 = done_cnt;
        gen(6'b100011, 6'd0);
        void'(exp_q.pop_back());
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 50) begin @(negedge clk); #1; cnt++; end
        check("midrd_reached", exp_q.size(), 0);
        exp_q.delete();
        check("midrd_state", int'(state), 3);
        check("midrd_iord", int'(iord), 1);
        clr_n = 1'b0;
        #1;
        check("midrd_async_outs", int'(outs), 0);
        check("midrd_async_state", int'(state), 0);
        @(posedge clk); @(posedge clk); #1;
        clr_n = 1'b1;
        check("midrd_no_done", done_cnt - d0, 0);
        run(6'b001000, 6'd0);

        // randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: run(6'b100011, 6'($urandom));
                1: run(6'b101011, 6'($urandom));
                2: run(6'b000000, rfn[$urandom_range(0, 4)]);
                3: run(6'b000100, 6'($urandom));
                4: run(6'b001000, 6'($urandom));
                default: run(6'b000010, 6'($urandom));
            endcase
        end

        // unknown opcode locks up until reset
        run(6'b111111, 6'd0);
        do_reset(2);
        run(6'b001000, 6'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
